alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0: requester favoured by the first contended grant after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  operation from requester N accepted this cycle.
REQ-006 reqN_op  input  3  opcode: 0 ADD, 1 SUB, 2 SL, 3 SR, 4 OR, 5 AND, 6 XOR, 7 POW.
REQ-007 reqN_a, reqN_b  input  16 each  operands.
REQ-008 rsp_valid  output  1  result register holds an undelivered result.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_id  output  1  requester that issued the held result.
REQ-011 rsp_out  output  16  ALU result.
REQ-012 rsp_flags  output  4  {sign, zero, parity, overflow}.
REQ-013 ops_cnt0, ops_cnt1  output  16 each  saturating count of accepted operations per requester.

Function
REQ-014 Arbiter SHALL accept at most one operation per cycle; accept condition = grant & reqN_valid & slot_free, where slot_free = !rsp_valid | rsp_ready.
REQ-015 Only one valid requester: it SHALL be granted; both valid: the one not most recently accepted SHALL be granted; neither: no grant.
REQ-016 last_grant SHALL update only on an accepted handshake, never on an unaccepted valid.
REQ-017 reqN_ready SHALL be combinational, asserted only for the granted requester while slot_free; never for both.
REQ-018 Accepted operation SHALL be computed combinationally and registered; rsp_valid rises the next cycle (latency 1).
REQ-019 Result SHALL be held stable (rsp_out, rsp_flags, rsp_id) while rsp_valid & !rsp_ready.
REQ-020 rsp_ready & rsp_valid with a simultaneous accept SHALL load the new result, rsp_valid stays 1 (throughput 1/cycle); without accept rsp_valid SHALL drop next cycle.
REQ-021 ADD/SUB SHALL be 16-bit modulo; SL/SR shift A by B[1:0] logically; OR/AND/XOR bitwise; POW = A[1:0] raised to B[1:0], zero-extended, 0^0 = 1.
REQ-022 sign = out[15] for ADD/SUB, else 0; zero = (out == 0); parity = even parity (1 when out has an even number of ones); overflow = signed overflow for ADD (A,B same sign, out differs) and SUB (A,B differ in sign, out differs from A), else 0.
REQ-023 ops_cntN SHALL increment on each accept from N and saturate at 16'hFFFF.
REQ-024 FSM states IDLE (rsp_valid=0) and FULL (rsp_valid=1): IDLE->FULL on accept; FULL->IDLE on rsp handshake without accept; FULL->FULL otherwise.
REQ-025 Requester changing op/operands while valid & !ready SHALL be tolerated; the value sampled on the accept cycle is used.

Reset
REQ-026 On rst: state IDLE, rsp_valid=0, rsp_out=0, rsp_flags=0, rsp_id=0, ops_cnt0=ops_cnt1=0, last_grant = !RR_INIT.
REQ-027 rst asserted mid-transaction SHALL discard the held result; reqN_ready SHALL be 0 during rst.

Structure
REQ-028 Shared package alu_pkg SHALL hold the opcode enum, flag-index constants and result/flag struct.
REQ-029 Datapath SHALL be a separate combinational sub-module alu16_core (op, a, b -> out, flags); alu_arbiter holds arbitration, FSM, result register and counters.

Verification
REQ-030 Single requester: req0 ADD 16'h7FFF+16'h0001, rsp_ready=1 -> next cycle rsp_out=16'h8000, flags sign=1 zero=0 parity=0 overflow=1, rsp_id=0.
REQ-031 Contention: both valid continuously after reset (RR_INIT=0), rsp_ready=1 -> accepts alternate 0,1,0,1 one per cycle; rsp_id follows.
REQ-032 Backpressure: rsp_ready=0 for 3 cycles with both valid -> reqN_ready=0, result held unchanged; raising rsp_ready accepts the next op in the same cycle.
REQ-033 Opcodes: SUB 0x0000-0x0001 -> 0xFFFF, sign=1, overflow=0; POW A=0,B=0 -> 1; SL 0x8001 by 1 -> 0x0002; XOR equal operands -> 0, zero=1, parity=1.
REQ-034 Reset mid-stream: rst while rsp_valid=1 -> next cycle rsp_valid=0, counters 0, first contended grant goes to RR_INIT.
REQ-035 Counter saturation: force/drive 65536 accepts on req1 -> ops_cnt1 stays 16'hFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding, flag bit positions and the packed result bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SL  = 3'd2,
    OP_SR  = 3'd3,
    OP_OR  = 3'd4,
    OP_AND = 3'd5,
    OP_XOR = 3'd6,
    OP_POW = 3'd7
  } alu_op_e;

  localparam int FLG_OVF  = 0;
  localparam int FLG_PAR  = 1;
  localparam int FLG_ZERO = 2;
  localparam int FLG_SIGN = 3;

  typedef struct packed {
    logic [15:0] out;
    logic [3:0]  flags;
  } alu_res_t;

endpackage

// File: rtl/alu16_core.sv
// Purely combinational 16-bit ALU producing result and {sign, zero, parity, overflow}.
module alu16_core
  import alu_pkg::*;
(
  input  alu_op_e     op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output alu_res_t    res
);

  logic [15:0] out;
  logic [15:0] pw;
  logic        sign;
  logic        ovf;

  // a[1:0] ** b[1:0] by repeated multiply; empty product gives 0^0 = 1
  always_comb begin
    pw = 16'd1;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < b[1:0]) pw = pw * {14'd0, a[1:0]};
    end
  end

  always_comb begin
    out  = '0;
    sign = 1'b0;
    ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        out  = a + b;
        sign = out[15];
        ovf  = (a[15] == b[15]) && (out[15] != a[15]);
      end
      OP_SUB: begin
        out  = a - b;
        sign = out[15];
        ovf  = (a[15] != b[15]) && (out[15] != a[15]);
      end
      OP_SL:   out = a << b[1:0];
      OP_SR:   out = a >> b[1:0];
      OP_OR:   out = a | b;
      OP_AND:  out = a & b;
      OP_XOR:  out = a ^ b;
      OP_POW:  out = pw;
      default: out = '0;
    endcase
  end

  always_comb begin
    res                 = '0;
    res.out             = out;
    res.flags[FLG_SIGN] = sign;
    res.flags[FLG_ZERO] = (out == 16'd0);
    res.flags[FLG_PAR]  = ~^out;
    res.flags[FLG_OVF]  = ovf;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a shared ALU with a one-entry result register.
// Latency 1 from accept to rsp_valid; requests stall while the result is held and not consumed.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_out,
  output logic [3:0]  rsp_flags,
  output logic [15:0] ops_cnt0,
  output logic [15:0] ops_cnt1
);

  typedef enum logic {IDLE, FULL} state_e;

  state_e      state;
  logic        last_grant;
  logic        gnt_any;
  logic        gnt_id;
  logic        slot_free;
  logic        accept;
  alu_op_e     sel_op;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  alu_res_t    alu_res;

  // Under contention the requester not served last wins; otherwise the lone valid one
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~last_grant;
    else                          gnt_id = req1_valid;
  end

  assign slot_free  = (state == IDLE) | rsp_ready;
  assign req0_ready = !rst & slot_free & gnt_any & !gnt_id;
  assign req1_ready = !rst & slot_free & gnt_any &  gnt_id;
  assign accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);
  assign rsp_valid  = (state == FULL);

  assign sel_op = alu_op_e'(gnt_id ? req1_op : req0_op);
  assign sel_a  = gnt_id ? req1_a : req0_a;
  assign sel_b  = gnt_id ? req1_b : req0_b;

  alu16_core u_core (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .res (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rsp_out    <= '0;
      rsp_flags  <= '0;
      rsp_id     <= 1'b0;
      ops_cnt0   <= '0;
      ops_cnt1   <= '0;
      last_grant <= ~RR_INIT;
    end else begin
      case (state)
        IDLE:    if (accept) state <= FULL;
        FULL:    if (rsp_ready && !accept) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (accept) begin
        rsp_out    <= alu_res.out;
        rsp_flags  <= alu_res.flags;
        rsp_id     <= gnt_id;
        last_grant <= gnt_id;
        if (!gnt_id && ops_cnt0 != 16'hFFFF) ops_cnt0 <= ops_cnt0 + 16'd1;
        if ( gnt_id && ops_cnt1 != 16'hFFFF) ops_cnt1 <= ops_cnt1 + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter against an arithmetic reference model plus literal spot checks.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_out, ops_cnt0, ops_cnt1;
  logic [3:0]  rsp_flags;

  int n_chk  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  // reference model state
  bit          m_valid;
  int          m_out, m_flags, m_id, m_cnt0, m_cnt1, m_last;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags),
    .ops_cnt0(ops_cnt0), .ops_cnt1(ops_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int s16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // returns {out[15:0], sign, zero, parity, overflow} computed with plain integer arithmetic
  function automatic int alu_model(input int op, input int a, input int b);
    int full, o, r;
    bit s, ov;
    s = 0; ov = 0; o = 0;
    case (op)
      0: begin full = s16(a) + s16(b); o = (a + b) % 65536; s = (o >= 32768);
               ov = (full > 32767) || (full < -32768); end
      1: begin full = s16(a) - s16(b); o = (a - b + 65536) % 65536; s = (o >= 32768);
               ov = (full > 32767) || (full < -32768); end
      2: o = (a * (1 << (b % 4))) % 65536;
      3: o = a / (1 << (b % 4));
      4: o = a | b;
      5: o = a & b;
      6: o = a ^ b;
      default: begin r = 1; for (int k = 0; k < b % 4; k++) r = r * (a % 4); o = r; end
    endcase
    return (o << 4) | (int'(s) << 3) | (int'(o == 0) << 2)
           | (int'($countones(o) % 2 == 0) << 1) | int'(ov);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_out = 0; m_flags = 0; m_id = 0;
    m_cnt0 = 0; m_cnt1 = 0; m_last = 1;
  endtask

  // compare process: check every cycle at the falling edge, then advance the model
  always @(negedge clk) begin
    if (run) begin
      int  win, r;
      bit  slot, e0, e1;
      slot = !m_valid || rsp_ready;
      if (req0_valid && req1_valid) win = 1 - m_last;
      else                          win = req1_valid ? 1 : 0;
      e0 = !rst && slot && req0_valid && win == 0;
      e1 = !rst && slot && req1_valid && win == 1;
      chk("req0_ready", int'(req0_ready), int'(e0));
      chk("req1_ready", int'(req1_ready), int'(e1));
      chk("rsp_valid",  int'(rsp_valid),  int'(m_valid));
      chk("rsp_id",     int'(rsp_id),     m_id);
      chk("rsp_out",    int'(rsp_out),    m_out);
      chk("rsp_flags",  int'(rsp_flags),  m_flags);
      chk("ops_cnt0",   int'(ops_cnt0),   m_cnt0);
      chk("ops_cnt1",   int'(ops_cnt1),   m_cnt1);
      if (rst) model_reset();
      else if (e0 || e1) begin
        r = e1 ? alu_model(int'(req1_op), int'(req1_a), int'(req1_b))
               : alu_model(int'(req0_op), int'(req0_a), int'(req0_b));
        m_out = r >> 4; m_flags = r & 15; m_id = win; m_last = win; m_valid = 1;
        if (e0 && m_cnt0 < 65535) m_cnt0++;
        if (e1 && m_cnt1 < 65535) m_cnt1++;
      end else if (m_valid && rsp_ready) m_valid = 0;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set0(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  initial begin
    rst = 1; rsp_ready = 0;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    cyc();
    model_reset();
    run = 1;
    cyc();
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset rsp_out",   int'(rsp_out),   0);
    chk("reset ops_cnt0",  int'(ops_cnt0),  0);

    // single requester ADD overflow
    rst = 0; rsp_ready = 1;
    set0(1, 3'd0, 16'h7FFF, 16'h0001);
    cyc();
    chk("add rsp_valid", int'(rsp_valid), 1);
    chk("add rsp_out",   int'(rsp_out),   'h8000);
    chk("add flags",     int'(rsp_flags), 'b1001);
    chk("add rsp_id",    int'(rsp_id),    0);

    // opcode spot checks, back to back
    set0(1, 3'd1, 16'h0000, 16'h0001); cyc();
    chk("sub out", int'(rsp_out), 'hFFFF);
    chk("sub flags", int'(rsp_flags), 'b1010);
    set0(1, 3'd7, 16'h0000, 16'h0000); cyc();
    chk("pow00 out", int'(rsp_out), 1);
    set0(1, 3'd7, 16'h0003, 16'h0003); cyc();
    chk("pow33 out", int'(rsp_out), 27);
    set0(1, 3'd2, 16'h8001, 16'h0001); cyc();
    chk("sl out", int'(rsp_out), 'h0002);
    set0(1, 3'd6, 16'h1234, 16'h1234); cyc();
    chk("xor out", int'(rsp_out), 0);
    chk("xor flags", int'(rsp_flags), 'b0110);
    set0(0, 0, 0, 0); cyc();

    // contention right after reset alternates starting at requester 0
    rst = 1; cyc(); rst = 0;
    set0(1, 3'd0, 16'h0001, 16'h0002);
    set1(1, 3'd4, 16'h00F0, 16'h000F);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr rsp_id",  int'(rsp_id),  i % 2);
      chk("rr rsp_out", int'(rsp_out), (i % 2) ? 'hFF : 3);
    end

    // backpressure holds the result and blocks both requesters
    rsp_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp req0_ready", int'(req0_ready), 0);
      chk("bp req1_ready", int'(req1_ready), 0);
      chk("bp rsp_out",    int'(rsp_out),    'hFF);
      chk("bp rsp_id",     int'(rsp_id),     1);
    end
    rsp_ready = 1; #1;
    chk("bp release req0_ready", int'(req0_ready), 1);
    cyc();
    chk("bp release rsp_id", int'(rsp_id), 0);

    // reset while a result is held
    rst = 1; #1;
    chk("rst req0_ready", int'(req0_ready), 0);
    cyc();
    chk("rst rsp_valid", int'(rsp_valid), 0);
    chk("rst ops_cnt0",  int'(ops_cnt0),  0);
    chk("rst ops_cnt1",  int'(ops_cnt1),  0);
    rst = 0; cyc();
    chk("rst first grant", int'(rsp_id), 0);

    // randomized traffic, including operand changes while stalled
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2) != 0)
        set0($urandom_range(0, 3) != 0, 3'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 2) != 0)
        set1($urandom_range(0, 3) != 0, 3'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        req0_a = 16'($urandom_range(0, 3)); req1_b = 16'($urandom_range(0, 3));
      end
      cyc();
    end

    // counter saturation on requester 1
    rst = 1; cyc(); rst = 0;
    rsp_ready = 1;
    set0(0, 0, 0, 0);
    set1(1, 3'd0, 16'h0001, 16'h0001);
    repeat (65540) cyc();
    chk("sat ops_cnt1", int'(ops_cnt1), 'hFFFF);
    chk("sat ops_cnt0", int'(ops_cnt0), 0);

    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
